// File: rtl/bus_fifo.sv
// bus_fifo: FIFO that parks values from the shared tri-state data bus and
// drives the oldest entry back onto the same bus when output-enabled.
// Show-ahead head, no fall-through bypass, pointers carry an extra wrap bit.
// Optional build macro FIFO_ERR_EN adds sticky overflow/underflow outputs.
module bus_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             wr,
  input  logic             rd,
  input  logic             oe,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
`ifdef FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head;
  logic             push_ok;
  logic             pop_ok;

  // A push is still accepted at full when a pop frees the head slot this edge.
  always_comb begin
    push_ok  = wr && (!full || rd);
    pop_ok   = rd && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer state; reset wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not cleared; only the write is gated by reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus;
    end
  end

  // Status flags derived purely from registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level = wr_ptr_q - rd_ptr_q;
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Never drive stale or undefined data: empty or in-reset releases the bus.
  assign bus = (oe && !empty && reset) ? head : {WIDTH{1'bz}};

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (wr && full && !rd);
    unf_d = unf_q | (rd && empty);
  end

  // Error flag state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: doc/bus_fifo.md
Name: bus_fifo

Overview:
- Buffered consumer on the shared 8-bit tri-state data bus, alongside the loadable up/down counter.
- Captures bus values on a write strobe and stores them first-in-first-out.
- Drives the oldest entry back onto the same bus when output-enabled, so counter values can be parked and later reloaded through the counter's parallel-load input.
- Single clock domain, no combinational path from the bus to full/empty.

Parameters:
- WIDTH, 8, data width of the bus and of each entry.
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- Local AW = log2(DEPTH). Pointers are AW+1 bits wide (extra wrap bit).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- bus  inout  WIDTH  shared data bus; sampled on write, driven on output-enable.
- wr  input  1  push request: capture bus into tail at next rising edge.
- rd  input  1  pop request: discard head at next rising edge.
- oe  input  1  drive head entry onto bus.
- full  output  1  high when level == DEPTH.
- empty  output  1  high when level == 0.
- level  output  AW+1  current number of stored entries, 0..DEPTH.

Behaviour:
- Reset (reset==0 at rising edge):
  - wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0.
  - Storage array is not cleared.
  - reset has priority over wr/rd in the same cycle.
- Bus drive (combinational):
  - bus = head entry when oe==1 AND empty==0 AND reset==1; otherwise all-Z.
  - Never drive X: empty or in-reset forces Z even with oe=1.
- Show-ahead read: head = mem[rd_ptr[AW-1:0]], valid whenever empty==0. No read latency.
- Push accepted when wr==1 AND (full==0 OR rd==1):
  - mem[wr_ptr] <= bus; wr_ptr increments.
- Pop accepted when rd==1 AND empty==0:
  - rd_ptr increments.
- Latency: a value pushed at edge N is visible on head / empty==0 from edge N onward (one cycle after wr is sampled).
- Simultaneous wr & rd:
  - Not empty: both accepted; level unchanged, order preserved.
  - Full: both accepted; head advances, new value goes to the freed slot.
  - Empty: push only; rd ignored. There is no fall-through bypass.
- Overflow: wr with full==1 and rd==0 drops the write; pointers and level unchanged.
- Underflow: rd with empty==1 is ignored.
- Self-loop: oe==1 with wr==1 pushes the current head value; legal and defined. With rd also high, this rotates the queue.
- Wrap-around: pointers count modulo 2*DEPTH.
  - full = (pointer MSBs differ AND lower AW bits equal).
  - empty = (pointers equal).
  - level = wr_ptr - rd_ptr, taken modulo 2^(AW+1).
- full, empty and level are registered-state derived; they update only at rising edges.
- Bus contention (another driver active while oe==1) is the system's responsibility; the block does not detect it.

Optional Feature:
- Macro: FIFO_ERR_EN.
- Defined: adds outputs overflow (1) and underflow (1).
  - Sticky high from the edge after a dropped write (overflow) or an ignored pop (underflow).
  - Cleared only by reset (both 0 after reset).
- Not defined: ports do not exist; dropped writes and ignored pops are silent. Core behaviour is identical in both builds.

Test Plan:
- All tests use DEPTH=4 unless stated.
- Reset: hold reset=0 one edge with oe=1, wr=1 -> empty=1, full=0, level=0, bus=Z; contents of any prior writes are not visible.
- Fill: bench drives bus 0x11,0x22,0x33,0x44 with wr=1, oe=0 for 4 edges -> level 1,2,3,4, full=1 after the 4th edge; then oe=1 -> bus=0x11.
- Overflow: at full, bench drives 0x55 with wr=1, rd=0 -> level stays 4, head still 0x11; with FIFO_ERR_EN, overflow=1 after the edge and remains 1.
- Drain: rd=1, oe=1 for 4 edges -> bus reads 0x11,0x22,0x33,0x44, then Z; empty=1; a 5th rd leaves level=0 and, with FIFO_ERR_EN, sets underflow=1.
- Concurrent: at level 2, wr=1 and rd=1 with bus=0xA5 -> level stays 2, head advances to the next entry. At full, the same stimulus -> accepted, full stays 1. At empty, the same stimulus -> level=1, head=0xA5.
- Wrap and mid-run reset:
  - 10 back-to-back push/pop pairs of values 0x00..0x09 -> pops return them in order across pointer wrap.
  - At level 3, reset=0 for one edge -> empty=1, level=0, bus=Z next cycle.
